// File: rtl/pc_sequencer.sv
// Program-counter sequencer in front of the I-cache: picks PC+4 or the PC-relative branch/jump target.
// Latency: a redirect lands on PC one cycle after it is sampled, or one cycle after busy falls if stalled.
// Backpressure: INSTR/DATA_BUSYWAIT freeze PC; a redirect seen while frozen is parked and applied on release.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          OFFSET_W    = 8,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   INSTR_BUSYWAIT,
    input  logic                   DATA_BUSYWAIT,
    input  logic                   JUMP,
    input  logic                   BRANCH,
    input  logic                   ZERO,
    input  logic [OFFSET_W-1:0]    OFFSET,
    output logic [31:0]            PC,
    output logic                   REDIRECT,
    output logic                   STALLED,
    output logic [STALL_CNT_W-1:0] STALL_CNT
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic                   redirect_q, redirect_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [31:0]            pend_tgt_q, pend_tgt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        busy;
    logic        take;
    logic [31:0] sext;
    logic [31:0] pc_inc;
    logic [31:0] tgt;

    // The instruction is not valid while the I-cache misses, so its redirect fields are ignored.
    assign busy   = INSTR_BUSYWAIT | DATA_BUSYWAIT;
    assign take   = ~INSTR_BUSYWAIT & (JUMP | (BRANCH & ZERO));
    assign sext   = {{(32-OFFSET_W){OFFSET[OFFSET_W-1]}}, OFFSET};
    assign pc_inc = pc_q + 32'd4;
    assign tgt    = pc_inc + {sext[29:0], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redirect_d  = 1'b0;
        pend_vld_d  = pend_vld_q;
        pend_tgt_d  = pend_tgt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (busy) begin
                    state_d = ST_STALL;
                    if (take) begin
                        pend_tgt_d = tgt;
                        pend_vld_d = 1'b1;
                    end
                end else if (take) begin
                    pc_d       = tgt;
                    redirect_d = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_STALL: begin
                if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
                // First redirect captured during a stall wins; later ones are dropped.
                if (take && !pend_vld_q) begin
                    pend_tgt_d = tgt;
                    pend_vld_d = 1'b1;
                end
                if (!busy) begin
                    state_d    = ST_RUN;
                    pc_d       = pend_vld_q ? pend_tgt_q : pc_inc;
                    redirect_d = pend_vld_q;
                    pend_vld_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            redirect_q  <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_tgt_q  <= 32'h0000_0000;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            pend_vld_q  <= pend_vld_d;
            pend_tgt_q  <= pend_tgt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC        = pc_q;
    assign REDIRECT  = redirect_q;
    assign STALLED   = (state_q == ST_STALL);
    assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: main instance at reset PC 0, plus a wrap/saturation instance.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_w_n;
    logic        ib, db, jmp, br, zr;
    logic [7:0]  off;

    logic [31:0] pc;
    logic        redir;
    logic        stalled;
    logic [15:0] cnt;

    logic [31:0] w_pc;
    logic        w_redir;
    logic        w_stalled;
    logic [1:0]  w_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .OFFSET_W   (8),
        .STALL_CNT_W(16)
    ) dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .INSTR_BUSYWAIT(ib),
        .DATA_BUSYWAIT (db),
        .JUMP          (jmp),
        .BRANCH        (br),
        .ZERO          (zr),
        .OFFSET        (off),
        .PC            (pc),
        .REDIRECT      (redir),
        .STALLED       (stalled),
        .STALL_CNT     (cnt)
    );

    pc_sequencer #(
        .RESET_PC   (32'hFFFF_FFFC),
        .OFFSET_W   (8),
        .STALL_CNT_W(2)
    ) dut_wrap (
        .CLK           (clk),
        .RESET         (rst_w_n),
        .INSTR_BUSYWAIT(ib),
        .DATA_BUSYWAIT (db),
        .JUMP          (jmp),
        .BRANCH        (br),
        .ZERO          (zr),
        .OFFSET        (off),
        .PC            (w_pc),
        .REDIRECT      (w_redir),
        .STALLED       (w_stalled),
        .STALL_CNT     (w_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [31:0] e_pc, input logic e_redir,
                            input logic e_stalled, input logic [15:0] e_cnt);
        chk({tag, ".pc"},       pc,              e_pc);
        chk({tag, ".redirect"}, {31'd0, redir},   {31'd0, e_redir});
        chk({tag, ".stalled"},  {31'd0, stalled}, {31'd0, e_stalled});
        chk({tag, ".stall_cnt"}, {16'd0, cnt},    {16'd0, e_cnt});
    endtask

    initial begin
        rst_n = 1'b0; rst_w_n = 1'b0;
        ib = 1'b0; db = 1'b0; jmp = 1'b0; br = 1'b0; zr = 1'b0; off = 8'h00;

        // 1: reset, boot cycle, then sequential fetch
        step();
        chk_main("reset", 32'd0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        step(); chk_main("boot",  32'd0,  1'b0, 1'b0, 16'd0);
        step(); chk_main("seq4",  32'd4,  1'b0, 1'b0, 16'd0);
        step(); chk_main("seq8",  32'd8,  1'b0, 1'b0, 16'd0);
        step(); chk_main("seq12", 32'd12, 1'b0, 1'b0, 16'd0);

        // 2: taken branches back to back, then not-taken branch
        br = 1'b1; zr = 1'b1; off = 8'hFE;
        step(); chk_main("br12to8", 32'd8, 1'b1, 1'b0, 16'd0);
        step(); chk_main("br8to4",  32'd4, 1'b1, 1'b0, 16'd0);
        br = 1'b0; zr = 1'b0;
        step(); chk_main("after_br", 32'd8, 1'b0, 1'b0, 16'd0);
        br = 1'b1; zr = 1'b0;
        step(); chk_main("br_not_taken", 32'd12, 1'b0, 1'b0, 16'd0);
        br = 1'b0;
        step(); chk_main("to16", 32'd16, 1'b0, 1'b0, 16'd0);

        // 3: I-cache stall for 3 cycles; jump while instruction invalid is ignored
        ib = 1'b1; jmp = 1'b1; off = 8'h10;
        step(); chk_main("istall1", 32'd16, 1'b0, 1'b1, 16'd0);
        step(); chk_main("istall2", 32'd16, 1'b0, 1'b1, 16'd1);
        step(); chk_main("istall3", 32'd16, 1'b0, 1'b1, 16'd2);
        ib = 1'b0; jmp = 1'b0;
        step(); chk_main("irelease", 32'd20, 1'b0, 1'b0, 16'd3);

        // 4: jump back to 16, then jump under D-cache stall; second jump mid-stall dropped
        jmp = 1'b1; off = 8'hFE;
        step(); chk_main("jmp20to16", 32'd16, 1'b1, 1'b0, 16'd3);
        off = 8'h03; db = 1'b1;
        step(); chk_main("dstall1", 32'd16, 1'b0, 1'b1, 16'd3);
        off = 8'h01;
        step(); chk_main("dstall2", 32'd16, 1'b0, 1'b1, 16'd4);
        db = 1'b0; jmp = 1'b0;
        step(); chk_main("drelease", 32'd32, 1'b1, 1'b0, 16'd5);
        step(); chk_main("after_rel", 32'd36, 1'b0, 1'b0, 16'd5);

        // 5: reset during a stall with a pending redirect
        db = 1'b1; jmp = 1'b1; off = 8'h05;
        step(); chk_main("pstall1", 32'd36, 1'b0, 1'b1, 16'd5);
        jmp = 1'b0;
        step(); chk_main("pstall2", 32'd36, 1'b0, 1'b1, 16'd6);
        rst_n = 1'b0;
        step(); chk_main("mid_reset", 32'd0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1; db = 1'b0;
        step(); chk_main("reboot",  32'd0, 1'b0, 1'b0, 16'd0);
        step(); chk_main("no_stray", 32'd4, 1'b0, 1'b0, 16'd0);

        // 6: wrap-around and saturating 2-bit stall counter on the second instance
        chk("wrap.reset_pc", w_pc, 32'hFFFF_FFFC);
        rst_w_n = 1'b1;
        step(); chk("wrap.boot", w_pc, 32'hFFFF_FFFC);
        step(); chk("wrap.pc0",  w_pc, 32'h0000_0000);
        jmp = 1'b1; off = 8'h80;
        step();
        chk("wrap.neg_jump", w_pc, 32'hFFFF_FE04);
        chk("wrap.neg_redir", {31'd0, w_redir}, 32'd1);
        jmp = 1'b0; db = 1'b1;
        step(); chk("wrap.cnt0", {30'd0, w_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("wrap.cnt_sat", {30'd0, w_cnt}, 32'd3);
        chk("wrap.stalled", {31'd0, w_stalled}, 32'd1);
        db = 1'b0;
        step();
        chk("wrap.cnt_sat_rel", {30'd0, w_cnt}, 32'd3);
        chk("wrap.pc_rel", w_pc, 32'hFFFF_FE08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
